// File: rtl/mul_sequencer_if.sv
// EX-stage multiply handshake: instruction/operand inputs from EX, stall and result back to it.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: latches a MUL, stalls the pipe while it
// iterates one multiplier bit per cycle, then presents the low WIDTH bits for one DONE cycle.
module mul_sequencer #(
    parameter int       WIDTH      = 32,
    parameter bit [2:0] CTRL_MUL   = 3'b100,
    parameter bit       EARLY_EXIT = 1'b1
) (
    input logic            clk_i,
    input logic            rst_i,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt;

    logic             acc_go;
    logic             last_iter;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;

    assign acc_go      = bus.valid_i & (bus.ALUCtrl_i == CTRL_MUL) & ~bus.flush_i;
    assign mplier_next = mplier >> 1;
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;

    // Early exit looks at the multiplier after this iteration's shift, so at least one RUN cycle always happens.
    assign last_iter = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_next == '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_go) begin
                        mcand  <= bus.data1_i;
                        mplier <= bus.data2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                        cnt    <= cnt + 1'b1;
                        if (last_iter) begin
                            result_q <= acc_next;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall is raised in the accept cycle itself and dropped as soon as a flush kills the multiply.
    assign bus.stall_o  = ((state == IDLE) && acc_go) || ((state == RUN) && !bus.flush_i);
    assign bus.busy_o   = (state == RUN);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result_q;
endmodule
